// File: rtl/stream_multiplier.sv
// -----------------------------------------------------------------------------
// stream_multiplier
//   Elastic, valid/ready pipelined multiplier. Each operation takes one beat of
//   operands plus a per-operation signed/unsigned mode and an opaque tag. It
//   returns the full double-width product, an overflow flag and the same tag.
//   The multiply and the overflow test are done ahead of stage 1. Later stages
//   only carry the result forward. Every stage has its own valid bit, so
//   bubbles collapse when the output is back-pressured.
//
// Ports
//   clk            : clock, rising edge
//   reset          : asynchronous active-low reset
//   in_valid       : operand beat valid
//   in_ready       : block accepts an operand beat this cycle
//   in_a, in_b     : operands, DATA_LEN bits
//   in_signed      : 1 = two's-complement multiply, 0 = unsigned multiply
//   in_tag         : tag carried with the operation
//   out_valid      : result beat valid
//   out_ready      : consumer accepts the result beat
//   out_result     : full product, 2*DATA_LEN bits
//   out_overflow   : product does not fit in DATA_LEN bits
//   out_tag        : tag of the result beat
//   inflight_count : number of valid operations held in the pipeline
// -----------------------------------------------------------------------------
module stream_multiplier #(
  parameter int DATA_LEN       = 32,
  parameter int PIPELINE_STAGE = 2,
  parameter int TAG_LEN        = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [DATA_LEN-1:0]                     in_a,
  input  logic [DATA_LEN-1:0]                     in_b,
  input  logic                                    in_signed,
  input  logic [TAG_LEN-1:0]                      in_tag,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [2*DATA_LEN-1:0]                   out_result,
  output logic                                    out_overflow,
  output logic [TAG_LEN-1:0]                      out_tag,
  output logic [$clog2(PIPELINE_STAGE+1)-1:0]     inflight_count
);

  localparam int PW = 2 * DATA_LEN;
  localparam int CW = $clog2(PIPELINE_STAGE + 1);
  localparam int LS = PIPELINE_STAGE - 1;

  // Full-width product. Each operand is extended to 2*DATA_LEN bits. The
  // extension is the sign bit in signed mode and zero in unsigned mode. The
  // low 2*DATA_LEN bits of the product are then exact in both modes.
  function automatic logic [PW-1:0] f_mul(input logic [DATA_LEN-1:0] a,
                                          input logic [DATA_LEN-1:0] b,
                                          input logic                s);
    logic [PW-1:0] ea;
    logic [PW-1:0] eb;
    ea = {{DATA_LEN{s & a[DATA_LEN-1]}}, a};
    eb = {{DATA_LEN{s & b[DATA_LEN-1]}}, b};
    return ea * eb;
  endfunction

  // Overflow: the upper half is not the extension of the lower half.
  function automatic logic f_ovf(input logic [PW-1:0] p, input logic s);
    logic [DATA_LEN-1:0] ext;
    ext = {DATA_LEN{s & p[DATA_LEN-1]}};
    return (p[PW-1:DATA_LEN] != ext);
  endfunction

  logic [PIPELINE_STAGE-1:0] r_valid;
  logic [PW-1:0]             r_res [PIPELINE_STAGE];
  logic                      r_ovf [PIPELINE_STAGE];
  logic [TAG_LEN-1:0]        r_tag [PIPELINE_STAGE];
  logic                      r_run;
  logic [CW-1:0]             r_count;

  logic [PIPELINE_STAGE-1:0] w_adv;
  logic                      w_in_fire;
  logic                      w_out_fire;
  logic [PW-1:0]             w_prod;
  logic                      w_ovf;

  // Stage i can load when it or any stage after it is empty, or when the
  // output is being taken. This lets out_ready ripple through a full pipe.
  always_comb begin
    logic v_all_full;
    v_all_full = 1'b1;
    w_adv      = {PIPELINE_STAGE{1'b0}};
    for (int i = LS; i >= 0; i--) begin
      v_all_full = v_all_full & r_valid[i];
      w_adv[i]   = out_ready | ~v_all_full;
    end
  end

  assign in_ready   = r_run & w_adv[0];
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_valid[LS] & out_ready;
  assign w_prod     = f_mul(in_a, in_b, in_signed);
  assign w_ovf      = f_ovf(w_prod, in_signed);

  // Input acceptance is enabled from the first rising edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Elastic stage registers. Data moves only behind a valid entry, so empty
  // stages keep their old contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= {PIPELINE_STAGE{1'b0}};
      for (int i = 0; i < PIPELINE_STAGE; i++) begin
        r_res[i] <= {PW{1'b0}};
        r_ovf[i] <= 1'b0;
        r_tag[i] <= {TAG_LEN{1'b0}};
      end
    end else begin
      if (w_adv[0]) begin
        r_valid[0] <= w_in_fire;
        if (w_in_fire) begin
          r_res[0] <= w_prod;
          r_ovf[0] <= w_ovf;
          r_tag[0] <= in_tag;
        end
      end
      for (int i = 1; i < PIPELINE_STAGE; i++) begin
        if (w_adv[i]) begin
          r_valid[i] <= r_valid[i-1];
          if (r_valid[i-1]) begin
            r_res[i] <= r_res[i-1];
            r_ovf[i] <= r_ovf[i-1];
            r_tag[i] <= r_tag[i-1];
          end
        end
      end
    end
  end

  // Occupancy counter. It stays unchanged when an input and an output
  // transfer happen on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= CW'(0);
    end else begin
      case ({w_in_fire, w_out_fire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid      = r_valid[LS];
  assign out_result     = r_res[LS];
  assign out_overflow   = r_ovf[LS];
  assign out_tag        = r_tag[LS];
  assign inflight_count = r_count;

endmodule
